// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: NB_DATA data bits LSB first, optional parity, NB_STOP stop bits,
// valid/ready delivery with overrun pulse. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_frame #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int NB_STOP    = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    // Vote completes one tick after the centre, so the whole frame is shifted by one tick.
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [TW-1:0] BIT_PT    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(NB_DATA - 1);
    localparam logic [3:0]    LAST_STOP = 4'(NB_STOP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_t;

    state_t             state;
    logic               sync1;
    logic               sync2;
    logic               line_d;
    logic [TW-1:0]      tick_cnt;
    logic [3:0]         bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic               par_err;
    logic               frm_err;
    logic               sample;

    // NOTE: synchroniser resets to the idle level so leaving reset is never mistaken for a start edge.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= i_rx;
            sync2  <= sync1;
            line_d <= sync2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            hist <= 2'b11;
        end else if (i_tick) begin
            hist <= {hist[0], sync2};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
    assign sample = sync2;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            // A DONE load later in this block overrides the handshake clear.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (line_d && !sync2) begin
                        state    <= START;
                        tick_cnt <= '0;
                        o_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (tick_cnt == START_PT) begin
                            if (sample) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                par_err  <= 1'b0;
                                frm_err  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == BIT_PT) begin
                            tick_cnt <= '0;
                            shreg    <= {sample, shreg[NB_DATA-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? PAR : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                PAR: begin
                    if (i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == BIT_PT) begin
                            tick_cnt <= '0;
                            // Even: error when data^parity is 1; odd mode inverts that sense.
                            par_err  <= (^shreg ^ sample) ^ (PARITY == 2);
                            state    <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == BIT_PT) begin
                            tick_cnt <= '0;
                            if (!sample) begin
                                frm_err <= 1'b1;
                            end
                            if (bit_cnt == LAST_STOP) begin
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    if (!o_valid || i_ready) begin
                        o_data       <= shreg;
                        o_parity_err <= par_err;
                        o_frame_err  <= frm_err;
                        o_valid      <= 1'b1;
                    end else begin
                        o_overrun <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 8E2, 5O1) driven with
// randomized frames and compared against a bit-level frame model.
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_IDX = 8;
`else
    localparam int SAMPLE_IDX = 7;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic line = 1'b1;
    logic ready_a = 1'b0;
    logic ready_b = 1'b0;
    int   sel = 0;
    logic rx_a, rx_b, rx_c;

    logic [7:0] data_a, data_b;
    logic [4:0] data_c;
    logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
    logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] got_a[$], got_b[$], got_c[$];
    logic [9:0] exp_a[$], exp_b[$], exp_c[$];
    int   ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;
    int   rise_a = 0;
    logic busy_a_q = 1'b0;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_frame #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY(0), .NB_STOP(1)) dut_a (
        .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx_a), .i_ready(ready_a),
        .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a), .o_frame_err(ferr_a),
        .o_overrun(ovr_a), .o_busy(busy_a));

    uart_rx_frame #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY(1), .NB_STOP(2)) dut_b (
        .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx_b), .i_ready(ready_b),
        .o_data(data_b), .o_valid(valid_b), .o_parity_err(perr_b), .o_frame_err(ferr_b),
        .o_overrun(ovr_b), .o_busy(busy_b));

    uart_rx_frame #(.NB_DATA(5), .OVERSAMPLE(16), .PARITY(2), .NB_STOP(1)) dut_c (
        .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx_c), .i_ready(ready_b),
        .o_data(data_c), .o_valid(valid_c), .o_parity_err(perr_c), .o_frame_err(ferr_c),
        .o_overrun(ovr_c), .o_busy(busy_c));

    // Record accepted words, overrun pulses and busy rises away from the active edge.
    always @(negedge clk) begin
        if (valid_a && ready_a) got_a.push_back({perr_a, ferr_a, data_a});
        if (valid_b && ready_b) got_b.push_back({perr_b, ferr_b, data_b});
        if (valid_c && ready_b) got_c.push_back({perr_c, ferr_c, 3'b000, data_c});
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
        if (ovr_c) ovr_cnt_c <= ovr_cnt_c + 1;
        if (busy_a && !busy_a_q) rise_a <= rise_a + 1;
        busy_a_q <= busy_a;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what a receiver must report for a frame built from these fields.
    function automatic logic [9:0] model(input logic [7:0] d, input int nd, input int pmode,
                                         input logic pbit, input logic [1:0] stops, input int nstop);
        logic [7:0] m = '0;
        int ones = 0;
        logic pe = 1'b0;
        logic fe = 1'b0;
        for (int i = 0; i < nd; i++) begin
            m[i[2:0]] = d[i[2:0]];
            ones += int'(d[i[2:0]]);
        end
        if (pmode != 0) begin
            ones += int'(pbit);
            pe = (pmode == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
        end
        for (int i = 0; i < nstop; i++) begin
            if (!stops[i[0]]) fe = 1'b1;
        end
        return {pe, fe, m};
    endfunction

    function automatic logic [15:0] mk_frame(input logic [7:0] d, input int nd, input int pmode,
                                             input logic pbit, input logic [1:0] stops, input int nstop);
        logic [15:0] v = '1;
        int k = 1;
        v[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            v[k[3:0]] = d[i[2:0]];
            k++;
        end
        if (pmode != 0) begin
            v[k[3:0]] = pbit;
            k++;
        end
        for (int i = 0; i < nstop; i++) begin
            v[k[3:0]] = stops[i[0]];
            k++;
        end
        return v;
    endfunction

    function automatic int flen(input int nd, input int pmode, input int nstop);
        return 1 + nd + ((pmode != 0) ? 1 : 0) + nstop;
    endfunction

    // One oversampling period: 4 clocks, tick on the last one; optional 1-cycle ready pulse after it.
    task automatic tick_period(input logic v, input logic rdy_pulse);
        line = v;
        repeat (3) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        if (rdy_pulse) begin
            ready_a = 1'b1;
            @(posedge clk);
            #1 ready_a = 1'b0;
        end
    endtask

    task automatic send_frame(input int which, input logic [15:0] v, input int n, input int idle,
                              input int gbit, input int gtick, input logic rdy_at_done);
        sel = which;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < 16; t++) begin
                logic b;
                b = v[i[3:0]];
                if (i == gbit && t == gtick) b = ~b;
                tick_period(b, rdy_at_done && (i == n - 1) && (t == SAMPLE_IDX));
            end
        end
        for (int i = 0; i < idle; i++) tick_period(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected 0", {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        n_checks++;
        if ({data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected 0", {data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b});
        end
        n_checks++;
        if ({data_c, valid_c, perr_c, ferr_c, ovr_c, busy_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_c: got %b expected 0", {data_c, valid_c, perr_c, ferr_c, ovr_c, busy_c});
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick_period(1'b1, 1'b0);
        n_checks++;
        if ({valid_a, busy_a, valid_b, busy_b, valid_c, busy_c} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 000000", {valid_a, busy_a, valid_b, busy_b, valid_c, busy_c});
        end
    endtask

    task automatic test_basic;
        int r0;
        ready_a = 1'b1;
        got_a.delete();
        exp_a.delete();
        r0 = rise_a;
        send_frame(0, mk_frame(8'hA5, 8, 0, 1'b0, 2'b11, 1), 10, 4, -1, -1, 1'b0);
        exp_a.push_back(10'h0A5);
        n_checks++;
        if (rise_a - r0 !== 1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: rises %0d busy %b valid %b, expected 1 0 0", rise_a - r0, busy_a, valid_a);
        end
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d;
            logic s;
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send_frame(0, mk_frame(d, 8, 0, 1'b0, {1'b1, s}, 1), 10, 3, -1, -1, 1'b0);
            exp_a.push_back(model(d, 8, 0, 1'b0, {1'b1, s}, 1));
        end
        n_checks++;
        if (got_a.size() !== exp_a.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d words expected %0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_checks++;
            if (got_a[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got %h expected %h", i, got_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_parity;
        ready_b = 1'b1;
        got_b.delete();
        exp_b.delete();
        got_c.delete();
        exp_c.delete();
        send_frame(1, mk_frame(8'h3C, 8, 1, 1'b1, 2'b11, 2), 12, 3, -1, -1, 1'b0);
        exp_b.push_back(10'h23C);
        send_frame(1, mk_frame(8'h3C, 8, 1, 1'b0, 2'b11, 2), 12, 3, -1, -1, 1'b0);
        exp_b.push_back(10'h03C);
        for (int f = 0; f < 5; f++) begin
            logic [7:0] d;
            logic p;
            logic [1:0] s;
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(1, 3)) | 2'b01;
            if ($urandom_range(0, 3) == 0) s = 2'($urandom_range(0, 3));
            send_frame(1, mk_frame(d, 8, 1, p, s, 2), 12, 3, -1, -1, 1'b0);
            exp_b.push_back(model(d, 8, 1, p, s, 2));
            d = 8'($urandom_range(0, 31));
            p = 1'($urandom_range(0, 1));
            send_frame(2, mk_frame(d, 5, 2, p, 2'b11, 1), flen(5, 2, 1), 3, -1, -1, 1'b0);
            exp_c.push_back(model(d, 5, 2, p, 2'b11, 1));
        end
        n_checks++;
        if (got_b.size() !== exp_b.size() || got_c.size() !== exp_c.size()) begin
            n_fail++;
            $display("FAIL parity_count: got %0d/%0d words expected %0d/%0d",
                     got_b.size(), got_c.size(), exp_b.size(), exp_c.size());
        end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            n_checks++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL parity_b[%0d]: got %h expected %h", i, got_b[i], exp_b[i]);
            end
        end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_checks++;
            if (got_c[i] !== exp_c[i]) begin
                n_fail++;
                $display("FAIL parity_c[%0d]: got %h expected %h", i, got_c[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_stop2;
        ready_b = 1'b1;
        ready_a = 1'b1;
        got_b.delete();
        got_a.delete();
        // Second stop bit low, then the line stays low: no retrigger without a new edge.
        send_frame(1, mk_frame(8'h55, 8, 1, 1'b0, 2'b01, 2), 12, 0, -1, -1, 1'b0);
        for (int i = 0; i < 60; i++) tick_period(1'b0, 1'b0);
        n_checks++;
        if (got_b.size() !== 1 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL stop2_hold: got %0d words busy %b expected 1 0", got_b.size(), busy_b);
        end
        n_checks++;
        if (got_b.size() > 0 && got_b[0] !== 10'h155) begin
            n_fail++;
            $display("FAIL stop2_word: got %h expected 155", got_b[0]);
        end
        for (int i = 0; i < 4; i++) tick_period(1'b1, 1'b0);
        send_frame(1, mk_frame(8'h5A, 8, 1, 1'b0, 2'b11, 2), 12, 3, -1, -1, 1'b0);
        n_checks++;
        if (got_b.size() !== 2 || got_b[got_b.size()-1] !== 10'h05A) begin
            n_fail++;
            $display("FAIL stop2_after: got %0d words last %h expected 2 05a", got_b.size(), got_b[got_b.size()-1]);
        end
        // Break: all-zero data with a low stop bit.
        send_frame(0, mk_frame(8'h00, 8, 0, 1'b0, 2'b00, 1), 10, 0, -1, -1, 1'b0);
        for (int i = 0; i < 20; i++) tick_period(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick_period(1'b1, 1'b0);
        n_checks++;
        if (got_a.size() !== 1 || got_a[0] !== 10'h100) begin
            n_fail++;
            $display("FAIL break: got %0d words first %h expected 1 100", got_a.size(), got_a[0]);
        end
    endtask

    task automatic test_glitch;
        int r0;
        logic [9:0] want;
        ready_a = 1'b1;
        got_a.delete();
        r0 = rise_a;
        sel = 0;
        for (int i = 0; i < 4; i++) tick_period(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) tick_period(1'b1, 1'b0);
        n_checks++;
        if (got_a.size() !== 0 || busy_a !== 1'b0 || valid_a !== 1'b0 || rise_a - r0 !== 1) begin
            n_fail++;
            $display("FAIL false_start: words %0d busy %b valid %b rises %0d expected 0 0 0 1",
                     got_a.size(), busy_a, valid_a, rise_a - r0);
        end
        // One-tick low pulse at the centre of data bit 2 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
        want = 10'h0FF;
`else
        want = 10'h0FB;
`endif
        send_frame(0, mk_frame(8'hFF, 8, 0, 1'b0, 2'b11, 1), 10, 3, 3, 7, 1'b0);
        n_checks++;
        if (got_a.size() !== 1 || got_a[0] !== want) begin
            n_fail++;
            $display("FAIL glitch_bit: got %0d words first %h expected 1 %h", got_a.size(), got_a[0], want);
        end
    endtask

    task automatic test_overrun;
        int o0;
        ready_a = 1'b0;
        got_a.delete();
        o0 = ovr_cnt_a;
        send_frame(0, mk_frame(8'h11, 8, 0, 1'b0, 2'b11, 1), 10, 2, -1, -1, 1'b0);
        n_checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_first: valid %b data %h expected 1 11", valid_a, data_a);
        end
        send_frame(0, mk_frame(8'h22, 8, 0, 1'b0, 2'b11, 1), 10, 2, -1, -1, 1'b0);
        n_checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h11 || ovr_cnt_a - o0 !== 1) begin
            n_fail++;
            $display("FAIL ovr_drop: valid %b data %h pulses %0d expected 1 11 1", valid_a, data_a, ovr_cnt_a - o0);
        end
        send_frame(0, mk_frame(8'h33, 8, 0, 1'b0, 2'b11, 1), 10, 2, -1, -1, 1'b1);
        n_checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h33 || ovr_cnt_a - o0 !== 1) begin
            n_fail++;
            $display("FAIL ovr_accept_load: valid %b data %h pulses %0d expected 1 33 1", valid_a, data_a, ovr_cnt_a - o0);
        end
        n_checks++;
        if (got_a.size() !== 1 || got_a[0] !== 10'h011) begin
            n_fail++;
            $display("FAIL ovr_handshake: got %0d words first %h expected 1 011", got_a.size(), got_a[0]);
        end
        ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0 || got_a.size() !== 2 || got_a[got_a.size()-1] !== 10'h033) begin
            n_fail++;
            $display("FAIL ovr_drain: valid %b words %0d last %h expected 0 2 033", valid_a, got_a.size(), got_a[got_a.size()-1]);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        ready_a = 1'b1;
        got_a.delete();
        v = mk_frame(8'h96, 8, 0, 1'b0, 2'b11, 1);
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 16; t++) tick_period(v[i[3:0]], 1'b0);
        end
        for (int t = 0; t < 8; t++) tick_period(v[4], 1'b0);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b expected 1", busy_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected 0", {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) tick_period(1'b1, 1'b0);
        send_frame(0, v, 10, 3, -1, -1, 1'b0);
        n_checks++;
        if (got_a.size() !== 1 || got_a[0] !== 10'h096) begin
            n_fail++;
            $display("FAIL mid_after: got %0d words first %h expected 1 096", got_a.size(), got_a[0]);
        end
    endtask

    task automatic test_back_to_back;
        int o0;
        ready_a = 1'b1;
        got_a.delete();
        exp_a.delete();
        o0 = ovr_cnt_a;
        for (int f = 0; f < 8; f++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_frame(0, mk_frame(d, 8, 0, 1'b0, 2'b11, 1), 10, 0, -1, -1, 1'b0);
            exp_a.push_back(model(d, 8, 0, 1'b0, 2'b11, 1));
        end
        for (int i = 0; i < 4; i++) tick_period(1'b1, 1'b0);
        n_checks++;
        if (got_a.size() !== exp_a.size() || ovr_cnt_a - o0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words %0d overruns expected %0d 0",
                     got_a.size(), ovr_cnt_a - o0, exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_checks++;
            if (got_a[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got %h expected %h", i, got_a[i], exp_a[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
